// File: rtl/planter_pkg.sv
//------------------------------------------------------------------------------
// Module : planter_pkg
// Desc   : Types and widths shared by Planter and its upstream feeders.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package planter_pkg;

    localparam int unsigned LEN_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_length_counter_if.sv
//------------------------------------------------------------------------------
// Module : frame_length_counter_if
// Desc   : Beat stream in, frame length out. len_ovf exists only with
//          FRAME_LEN_SAT_EN defined.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface frame_length_counter_if #(
    parameter int unsigned LEN_W = planter_pkg::LEN_W
);
    logic             in_valid;
    logic             in_last;
    logic             in_abort;
    logic             in_ready;
    logic             len_valid;
    logic             len_ready;
    logic [LEN_W-1:0] length;
    logic             busy;
`ifdef FRAME_LEN_SAT_EN
    logic             len_ovf;

    modport slave  (input  in_valid, in_last, in_abort, len_ready,
                    output in_ready, len_valid, length, busy, len_ovf);
    modport master (output in_valid, in_last, in_abort, len_ready,
                    input  in_ready, len_valid, length, busy, len_ovf);
`else
    modport slave  (input  in_valid, in_last, in_abort, len_ready,
                    output in_ready, len_valid, length, busy);
    modport master (output in_valid, in_last, in_abort, len_ready,
                    input  in_ready, len_valid, length, busy);
`endif
endinterface

`default_nettype wire

// File: rtl/frame_length_counter_len_hold_reg.sv
//------------------------------------------------------------------------------
// Module : len_hold_reg
// Desc   : One-entry valid/ready holding register with same-cycle load/consume.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module len_hold_reg #(
    parameter int unsigned W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_data,
    input  wire logic         i_ready,
    output logic              o_valid,
    output logic [W-1:0]      o_data,
    output logic              o_space
);
    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            // A load wins over a consume: back-to-back results, no bubble.
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_space = ~(r_valid & ~i_ready);

endmodule

`default_nettype wire

// File: rtl/frame_length_counter.sv
//------------------------------------------------------------------------------
// Module : frame_length_counter
// Desc   : Counts accepted beats per frame and presents each frame's length.
//          FRAME_LEN_SAT_EN: saturating count plus len_ovf flag.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_length_counter
    import planter_pkg::*;
#(
    parameter int unsigned LEN_W = planter_pkg::LEN_W
) (
    input  wire logic               clk,
    input  wire logic               rst,
    frame_length_counter_if.slave   bus
);
`ifdef FRAME_LEN_SAT_EN
    localparam int unsigned HOLD_W = LEN_W + 1;
`else
    localparam int unsigned HOLD_W = LEN_W;
`endif

    frame_state_t      r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic              w_acc, w_emit, w_space, w_hold_valid;
    logic [HOLD_W-1:0] w_hold_d, w_hold_q;
`ifdef FRAME_LEN_SAT_EN
    logic              r_ovf, w_ovf_nxt, w_inc_ovf;
`endif

    assign w_acc = bus.in_valid & w_space;

    always_comb begin
`ifdef FRAME_LEN_SAT_EN
        // Once the count has passed all-ones it stays pinned there.
        w_inc_ovf = r_ovf | (&r_cnt);
        w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + LEN_W'(1);
        w_hold_d  = {w_inc_ovf, w_cnt_inc};
`else
        w_cnt_inc = r_cnt + LEN_W'(1);
        w_hold_d  = w_cnt_inc;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
`ifdef FRAME_LEN_SAT_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef FRAME_LEN_SAT_EN
            r_ovf   <= w_ovf_nxt;
`endif
        end
    end

    // IDLE holds cnt at zero, so the same increment serves both states.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
`ifdef FRAME_LEN_SAT_EN
        w_ovf_nxt   = r_ovf;
`endif
        if (bus.in_abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
`ifdef FRAME_LEN_SAT_EN
            w_ovf_nxt   = 1'b0;
`endif
        end else if (w_acc) begin
            if (bus.in_last) begin
                w_emit      = 1'b1;
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
`ifdef FRAME_LEN_SAT_EN
                w_ovf_nxt   = 1'b0;
`endif
            end else begin
                w_state_nxt = COUNT;
                w_cnt_nxt   = w_cnt_inc;
`ifdef FRAME_LEN_SAT_EN
                w_ovf_nxt   = w_inc_ovf;
`endif
            end
        end
    end

    len_hold_reg #(
        .W (HOLD_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_emit),
        .i_data  (w_hold_d),
        .i_ready (bus.len_ready),
        .o_valid (w_hold_valid),
        .o_data  (w_hold_q),
        .o_space (w_space)
    );

    assign bus.in_ready  = w_space;
    assign bus.len_valid = w_hold_valid;
    assign bus.length    = w_hold_q[LEN_W-1:0];
    assign bus.busy      = (r_state == COUNT);
`ifdef FRAME_LEN_SAT_EN
    assign bus.len_ovf   = w_hold_q[LEN_W];
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_length_counter.sv
//------------------------------------------------------------------------------
// Module : tb_frame_length_counter
// Desc   : Directed self-checking bench for frame_length_counter (LEN_W = 4).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_length_counter;
    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    frame_length_counter_if #(.LEN_W(LW)) bus ();

    frame_length_counter #(.LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; checks happen 1 unit later.
    task automatic drv(input logic v, input logic l, input logic a, input logic r);
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.in_abort  = a;
        bus.len_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 1);
        tick(); tick();
        rst = 1'b0;
        drv(0, 0, 0, 1);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_len_valid", 32'(bus.len_valid), 0);
        chk("rst_length", 32'(bus.length), 0);
        chk("rst_busy", 32'(bus.busy), 0);
`ifdef FRAME_LEN_SAT_EN
        chk("rst_ovf", 32'(bus.len_ovf), 0);
`endif

        // 5-beat frame, sink always ready
        for (int i = 0; i < 5; i++) begin
            drv(1, i == 4, 0, 1);
            chk("f5_in_ready", 32'(bus.in_ready), 1);
            chk("f5_busy", 32'(bus.busy), (i > 0) ? 1 : 0);
            chk("f5_len_valid_low", 32'(bus.len_valid), 0);
            tick();
        end
        drv(0, 0, 0, 1);
        chk("f5_len_valid", 32'(bus.len_valid), 1);
        chk("f5_length", 32'(bus.length), 5);
        chk("f5_busy_end", 32'(bus.busy), 0);
        tick();
        chk("f5_len_valid_1cyc", 32'(bus.len_valid), 0);

        // single-beat frames every cycle
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 0, 1);
            chk("sb_in_ready", 32'(bus.in_ready), 1);
            tick();
            chk("sb_len_valid", 32'(bus.len_valid), 1);
            chk("sb_length", 32'(bus.length), 1);
        end
        drv(0, 0, 0, 1);
        tick();
        chk("sb_drain", 32'(bus.len_valid), 0);

        // 3-beat frame into a stalled sink, new frame offered meanwhile
        for (int i = 0; i < 3; i++) begin
            drv(1, i == 2, 0, 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drv(1, 0, 0, 0);
            chk("st_in_ready", 32'(bus.in_ready), 0);
            chk("st_len_valid", 32'(bus.len_valid), 1);
            chk("st_length", 32'(bus.length), 3);
            chk("st_busy", 32'(bus.busy), 0);
            tick();
        end
        drv(1, 0, 0, 1);
        chk("st_release_ready", 32'(bus.in_ready), 1);
        tick();
        chk("st_consumed", 32'(bus.len_valid), 0);
        chk("st_busy_new", 32'(bus.busy), 1);
        drv(1, 1, 0, 1);
        tick();
        chk("st_next_valid", 32'(bus.len_valid), 1);
        chk("st_next_length", 32'(bus.length), 2);
        drv(0, 0, 0, 1);
        tick();

        // abort on the last beat, then a 2-beat frame
        drv(1, 0, 0, 1); tick();
        drv(1, 0, 0, 1); tick();
        drv(1, 1, 1, 1); tick();
        drv(0, 0, 0, 1);
        chk("ab_no_emit", 32'(bus.len_valid), 0);
        chk("ab_busy", 32'(bus.busy), 0);
        drv(1, 0, 0, 1); tick();
        drv(1, 1, 0, 1); tick();
        drv(0, 0, 0, 1);
        chk("ab_next_valid", 32'(bus.len_valid), 1);
        chk("ab_next_length", 32'(bus.length), 2);
        tick();

        // held length consumed on the same edge a new frame completes
        drv(1, 0, 0, 0); tick();
        drv(1, 1, 0, 0); tick();
        drv(0, 0, 0, 0);
        chk("bb_held_length", 32'(bus.length), 2);
        drv(1, 1, 0, 1);
        chk("bb_in_ready", 32'(bus.in_ready), 1);
        tick();
        drv(0, 0, 0, 1);
        chk("bb_valid_stays", 32'(bus.len_valid), 1);
        chk("bb_new_length", 32'(bus.length), 1);
        tick();
        chk("bb_drain", 32'(bus.len_valid), 0);

        // abort honoured while stalled
        drv(1, 1, 0, 0); tick();
        drv(1, 0, 1, 0); tick();
        drv(0, 0, 0, 1);
        chk("sa_held", 32'(bus.length), 1);
        chk("sa_busy", 32'(bus.busy), 0);
        tick();

        // counter boundary
`ifdef FRAME_LEN_SAT_EN
        for (int i = 0; i < 17; i++) begin
            drv(1, i == 16, 0, 1);
            tick();
        end
        drv(0, 0, 0, 1);
        chk("sat_length", 32'(bus.length), 15);
        chk("sat_ovf", 32'(bus.len_ovf), 1);
        tick();
        for (int i = 0; i < 15; i++) begin
            drv(1, i == 14, 0, 1);
            tick();
        end
        drv(0, 0, 0, 1);
        chk("max_length", 32'(bus.length), 15);
        chk("max_ovf", 32'(bus.len_ovf), 0);
        tick();
`else
        for (int i = 0; i < 16; i++) begin
            drv(1, i == 15, 0, 1);
            tick();
        end
        drv(0, 0, 0, 1);
        chk("wrap_valid", 32'(bus.len_valid), 1);
        chk("wrap_length", 32'(bus.length), 0);
        tick();
`endif

        // reset mid-frame with a length held
        drv(1, 1, 0, 0); tick();
        drv(0, 0, 0, 0);
        chk("mr_held", 32'(bus.len_valid), 1);
        drv(1, 0, 0, 1); tick();
        drv(1, 0, 0, 1); tick();
        chk("mr_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        drv(0, 0, 0, 1);
        tick();
        rst = 1'b0;
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_len_valid", 32'(bus.len_valid), 0);
        chk("mr_length", 32'(bus.length), 0);
        drv(1, 1, 0, 1); tick();
        drv(0, 0, 0, 1);
        chk("mr_fresh_length", 32'(bus.length), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_length_counter.md
# frame_length_counter

Upstream feeder for `Planter`. Counts accepted beats of an incoming valid/ready frame stream, terminated by `in_last`, and presents each completed frame's beat count as a 32-bit `length` through a one-entry valid/ready output register. That `length` drives `Planter.length` directly. Frames can be discarded mid-way with `in_abort`.

## Interface
- `LEN_W`, default 32: width of the beat counter and of `length`. Must be 32 when driving `Planter`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  input beat present.
- `in_last`  input  1  qualifies the final beat of a frame; meaningful only when `in_valid` is high.
- `in_abort`  input  1  discards the frame in progress; sampled every cycle.
- `in_ready`  output  1  block can accept a beat this cycle.
- `len_valid`  output  1  `length` holds a completed frame count.
- `len_ready`  input  1  downstream consumes `length`.
- `length`  output  LEN_W  beat count of the last completed frame.
- `busy`  output  1  a frame is in progress (at least one beat accepted, no last yet).
- `len_ovf`  output  1  overflow flag for the held length; present only with `FRAME_LEN_SAT_EN`.

## Operation
- Beat acceptance: `acc = in_valid & in_ready`.
- Ready rule: `in_ready = ~(len_valid & ~len_ready)`. This is combinational from the output-register state and `len_ready`.
- Frame FSM states:
  - IDLE: `cnt` = 0.
  - COUNT: `cnt` = beats accepted so far in the current frame.
- FSM transitions:
  - IDLE → COUNT on `acc & ~in_last`, with `cnt` ← 1.
  - IDLE stays IDLE on `acc & in_last`: single-beat frame, emits length 1.
  - COUNT → COUNT on `acc & ~in_last`, with `cnt` ← `cnt`+1.
  - COUNT → IDLE on `acc & in_last`: emits `cnt`+1, then `cnt` ← 0.
- Abort:
  - `in_abort` forces IDLE with `cnt` ← 0 and emits nothing.
  - Abort takes priority over a same-cycle beat, including a last beat; that beat is consumed and dropped.
  - Abort does not touch the output register.
- Output register: EMPTY / FULL, tracked by `len_valid`.
  - An emit loads `length`, sets `len_valid`, and updates `len_ovf`.
  - `len_valid & len_ready` with no emit clears `len_valid`.
  - Emit and consume in the same cycle: the new value is loaded and `len_valid` stays 1 (back-to-back, no bubble).
  - `length` is stable while `len_valid & ~len_ready`.
- Arithmetic: `cnt`+1 is computed in LEN_W bits. Overflow behaviour is set under Configuration.
- `busy` = (state == COUNT).

## Timing
- Reset values:
  - `in_ready` = 1.
  - `len_valid` = 0.
  - `length` = 0.
  - `busy` = 0.
  - `len_ovf` = 0.
  - FSM in IDLE, `cnt` = 0.
- Reset mid-frame discards the partial count and any held length.
- Latency: `len_valid` rises one cycle after the clock edge that accepts the last beat.
- Throughput: one beat per cycle. With `len_ready` tied high, `in_ready` never drops and consecutive single-beat frames emit a length every cycle.
- Output stall: while `len_valid & ~len_ready`, `in_ready` = 0 and no beats are accepted; `cnt` holds.
- `in_abort` is still honoured while stalled.

## Configuration
- Macro: `FRAME_LEN_SAT_EN`.
- Defined:
  - The counter saturates at 2^LEN_W−1 and never wraps.
  - If a frame's true count exceeds 2^LEN_W−1, `length` = all ones and `len_ovf` = 1 for that result.
  - `len_ovf` is otherwise 0 and is reloaded on every emit.
- Undefined:
  - Counting wraps modulo 2^LEN_W, so a frame of exactly 2^LEN_W beats reports 0.
  - The `len_ovf` port is absent.

## Structure
- Shared package `planter_pkg` holds:
  - `LEN_W = 32`, also used by `Planter`.
  - The `frame_state_t` enum {IDLE, COUNT}.
- One sub-module is natural: `len_hold_reg`, the one-entry valid/ready holding register (load, consume, stall logic). It is parameterised by width and instantiated once.
- The FSM and counter stay in the top module.

## Test plan
- Reset, then a 5-beat frame with `len_ready`=1 → `length`=5 and `len_valid` high for exactly 1 cycle, 1 cycle after the last beat; `busy` high for cycles 1–4 of the frame.
- Single-beat frames every cycle ×4 with `len_ready`=1 → `length`=1 on 4 consecutive cycles; `in_ready` never low.
- 3-beat frame with `len_ready`=0 for 6 cycles, then a new frame offered → `length`=3 held stable, `in_ready`=0 throughout; after `len_ready`=1 the next frame is counted correctly.
- `in_abort` on beat 3 of a frame whose beat 3 is the last beat, then a 2-beat frame → no emit for the aborted frame; next `length`=2.
- Held length pending while `len_ready` rises on the same cycle a new last beat completes → new value loaded, `len_valid` stays 1, no lost or duplicated count.
- With `FRAME_LEN_SAT_EN` and LEN_W=4: 17-beat frame → `length`=15, `len_ovf`=1. Without the macro: 16-beat frame → `length`=0.
